// File: rtl/dm_port_arbiter.sv
// Single-port DM arbiter between MEM stage and debug/loader; response one cycle after grant, loser stalls.
// Debug is forced through after MAX_WAIT losses or while dbg_hold; optional counters behind ARB_STATS_EN.
module dm_port_arbiter #(
  parameter int MEMORY_BITS = 12,
  parameter int DATA_W      = 32,
  parameter int MAX_WAIT    = 8
) (
  input  logic                   input_clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [MEMORY_BITS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_stall,
  output logic                   cpu_rvalid,
  output logic [DATA_W-1:0]      cpu_rdata,
  input  logic                   dbg_hold,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic [MEMORY_BITS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]      dbg_wdata,
  output logic                   dbg_ack,
  output logic [DATA_W-1:0]      dbg_rdata,
  output logic                   dm_en,
  output logic                   dm_we,
  output logic [MEMORY_BITS-1:0] dm_addr,
  output logic [DATA_W-1:0]      dm_wdata,
  input  logic [DATA_W-1:0]      dm_rdata,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            dbg_grants
);

  typedef enum logic [2:0] {IDLE, CPU_RD, CPU_WR, DBG_RD, DBG_WR} resp_t;

  typedef struct packed {
    logic                   we;
    logic [MEMORY_BITS-1:0] addr;
    logic [DATA_W-1:0]      wdata;
  } dm_cmd_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;
  logic       force_dbg;
  logic       dbg_gnt;
  logic       cpu_gnt;
  resp_t      resp;
  resp_t      resp_next;
  dm_cmd_t    dm_cmd;

  // Grants are held off while reset is low so DM and response outputs read 0.
  assign force_dbg = dbg_req && (dbg_hold || wait_cnt == WAIT_LIMIT);
  assign dbg_gnt   = rst && dbg_req && (force_dbg || !cpu_req);
  assign cpu_gnt   = rst && cpu_req && !dbg_hold && !dbg_gnt;
  assign cpu_stall = cpu_req && !cpu_gnt;

  always_comb begin
    dm_cmd = '0;
    if (cpu_gnt) begin
      dm_cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    end else if (dbg_gnt) begin
      dm_cmd = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
    end
  end

  assign dm_en    = cpu_gnt | dbg_gnt;
  assign dm_we    = dm_cmd.we;
  assign dm_addr  = dm_cmd.addr;
  assign dm_wdata = dm_cmd.wdata;

  always_ff @(posedge input_clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge input_clk or negedge rst) begin
    if (!rst) begin
      resp <= IDLE;
    end else begin
      resp <= resp_next;
    end
  end

  always_comb begin
    resp_next  = IDLE;
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    dbg_ack    = 1'b0;
    dbg_rdata  = '0;
    if (cpu_gnt) begin
      resp_next = cpu_we ? CPU_WR : CPU_RD;
    end else if (dbg_gnt) begin
      resp_next = dbg_we ? DBG_WR : DBG_RD;
    end
    case (resp)
      CPU_RD: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = dm_rdata;
      end
      DBG_RD: begin
        dbg_ack   = 1'b1;
        dbg_rdata = dm_rdata;
      end
      DBG_WR: dbg_ack = 1'b1;
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] grant_cnt;

  always_ff @(posedge input_clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if (cpu_stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (dbg_gnt && grant_cnt != 32'hFFFF_FFFF) grant_cnt <= grant_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
  assign dbg_grants   = grant_cnt;
`else
  assign stall_cycles = '0;
  assign dbg_grants   = '0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural synchronous-read DM and a response scoreboard.
module tb_dm_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
`ifdef ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          input_clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_hold, dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dm_en, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic [31:0]   stall_cycles, dbg_grants;

  dm_port_arbiter #(.MEMORY_BITS(AW), .DATA_W(DW), .MAX_WAIT(8)) dut (
    .input_clk(input_clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_hold(dbg_hold), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .stall_cycles(stall_cycles), .dbg_grants(dbg_grants)
  );

  always #5 input_clk = ~input_clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge input_clk) begin
    if (dm_en) begin
      if (dm_we) mem[dm_addr] <= dm_wdata;
      else       dm_rdata     <= mem[dm_addr];
    end
  end

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  typedef struct { int due; logic [DW-1:0] data; } exp_t;
  exp_t cpu_q[$];
  exp_t dbg_q[$];
  logic cpu_due, dbg_due;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, want);
  endtask

  always @(posedge input_clk) cyc <= cyc + 1;

  // Responses are expected exactly one cycle after the issue that queued them.
  always @(negedge input_clk) begin
    cpu_due = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(cpu_due));
    if (cpu_due) begin
      check("cpu_rdata", cpu_rdata, cpu_q[0].data);
      void'(cpu_q.pop_front());
    end else begin
      check("cpu_rdata_idle", cpu_rdata, 0);
    end
    dbg_due = (dbg_q.size() > 0) && (dbg_q[0].due == cyc);
    check("dbg_ack", 32'(dbg_ack), 32'(dbg_due));
    if (dbg_due) begin
      check("dbg_rdata", dbg_rdata, dbg_q[0].data);
      void'(dbg_q.pop_front());
    end else begin
      check("dbg_rdata_idle", dbg_rdata, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge input_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge input_clk);
  endtask

  task automatic push_cpu(input logic [DW-1:0] d);
    cpu_q.push_back('{due: cyc + 1, data: d});
  endtask

  task automatic push_dbg(input logic [DW-1:0] d);
    dbg_q.push_back('{due: cyc + 1, data: d});
  endtask

  task automatic dbg_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] rd_want);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    push_dbg(we ? '0 : rd_want);
    mid();
    check("dbg_dm_en", 32'(dm_en), 1);
    check("dbg_dm_we", 32'(dm_we), 32'(we));
    check("dbg_dm_addr", 32'(dm_addr), 32'(a));
    if (we) check("dbg_dm_wdata", dm_wdata, d);
    next_cycle();
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mid();
    next_cycle();
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] rd_want);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (!we) push_cpu(rd_want);
    mid();
    check("cpu_stall_issue", 32'(cpu_stall), 0);
    check("cpu_dm_en", 32'(dm_en), 1);
    check("cpu_dm_we", 32'(dm_we), 32'(we));
    check("cpu_dm_addr", 32'(dm_addr), 32'(a));
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mid();
    check("cpu_stall_resp", 32'(cpu_stall), 0);
    next_cycle();
  endtask

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_hold = 0; dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    next_cycle();
    // reset: only cpu_stall follows cpu_req
    cpu_req = 1'b1; dbg_req = 1'b1;
    mid();
    check("rst_cpu_stall", 32'(cpu_stall), 1);
    check("rst_dm_en", 32'(dm_en), 0);
    check("rst_dm_addr", 32'(dm_addr), 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_dbg_grants", dbg_grants, 0);
    next_cycle();
    cpu_req = 1'b0; dbg_req = 1'b0; rst = 1'b1;
    next_cycle();

    // debug write then read back, plus DM preload for CPU tests
    dbg_access(1'b1, 12'd10, 32'h1234, '0);
    dbg_access(1'b0, 12'd10, '0, 32'h1234);
    dbg_access(1'b1, 12'd5, 32'hDEAD_BEEF, '0);

    // CPU read, CPU write (no pulse), CPU read-back
    cpu_access(1'b0, 12'd5, '0, 32'hDEAD_BEEF);
    cpu_access(1'b1, 12'd20, 32'h55, '0);
    cpu_access(1'b0, 12'd20, '0, 32'h55);

    // starvation from a clean reset so the counters isolate this scenario
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd5;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'd10;
    for (int k = 0; k < 8; k++) begin
      push_cpu(32'hDEAD_BEEF);
      mid();
      check("starve_cpu_stall", 32'(cpu_stall), 0);
      check("starve_cpu_addr", 32'(dm_addr), 5);
      next_cycle();
    end
    push_dbg(32'h1234);
    mid();
    check("starve_force_stall", 32'(cpu_stall), 1);
    check("starve_force_addr", 32'(dm_addr), 10);
    check("starve_force_en", 32'(dm_en), 1);
    next_cycle();
    dbg_req = 1'b0;
    push_cpu(32'hDEAD_BEEF);
    mid();
    check("starve_cpu_back", 32'(cpu_stall), 0);
    check("starve_cpu_back_addr", 32'(dm_addr), 5);
    next_cycle();
    cpu_req = 1'b0;
    mid();
    check("stats_stall_cycles", stall_cycles, 32'(STATS));
    check("stats_dbg_grants", dbg_grants, 32'(STATS));
    next_cycle();

    // dbg_hold: CPU locked out, debug writes addr 0..3 each acked
    cpu_req = 1'b1; cpu_addr = 12'd5; dbg_hold = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0 && k < 8) begin
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'(k / 2); dbg_wdata = 32'(100 + k / 2);
        push_dbg('0);
      end else begin
        dbg_req = 1'b0; dbg_we = 1'b0;
      end
      mid();
      check("hold_cpu_stall", 32'(cpu_stall), 1);
      check("hold_dm_en", 32'(dm_en), 32'(dbg_req));
      next_cycle();
    end
    dbg_hold = 1'b0;
    push_cpu(32'hDEAD_BEEF);
    mid();
    check("release_stall", 32'(cpu_stall), 0);
    check("release_dm_addr", 32'(dm_addr), 5);
    next_cycle();
    cpu_req = 1'b0;
    mid();
    next_cycle();
    dbg_access(1'b0, 12'd3, '0, 32'd103);
    dbg_access(1'b0, 12'd0, '0, 32'd100);

    // reset half a cycle after a CPU read grant: response discarded
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd5;
    mid();
    check("rmid_dm_en", 32'(dm_en), 1);
    rst = 1'b0;
    next_cycle();
    mid();
    check("rmid_cpu_stall", 32'(cpu_stall), 1);
    check("rmid_dm_en_rst", 32'(dm_en), 0);
    next_cycle();
    cpu_req = 1'b0; rst = 1'b1;
    mid();
    check("rmid_after_en", 32'(dm_en), 0);
    check("rmid_after_stall", 32'(cpu_stall), 0);
    check("rmid_after_stats", stall_cycles, 0);
    next_cycle();
    mid();
    next_cycle();

    check("cpu_q_drained", 32'(cpu_q.size()), 0);
    check("dbg_q_drained", 32'(dbg_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory (DM) between two requesters:
  - the pipeline MEM stage (CPU port);
  - a debug/loader port, used to preload data and inspect results before and after a run.
- Sits between the MEM stage and DM inside PL_CPU.
- Stalls the CPU when it loses arbitration.
- Bounds debug-port starvation with a wait counter.
- Returns read data one cycle after issue, matching DM's synchronous read.

Parameters:
- MEMORY_BITS, 12: DM word-address width; DM depth is 2^MEMORY_BITS.
- DATA_W, 32: data word width.
- MAX_WAIT, 8: cycles a pending debug request may lose to the CPU before it is forced through; legal range 1..255.

Ports:
- input_clk, input, 1: system clock, rising edge.
- rst, input, 1: one clock; reset is asynchronous and active-low.
- cpu_req, input, 1: MEM-stage access request; held while cpu_stall=1.
- cpu_we, input, 1: 1=write, 0=read.
- cpu_addr, input, MEMORY_BITS: CPU word address.
- cpu_wdata, input, DATA_W: CPU write data.
- cpu_stall, output, 1: CPU request pending and not granted this cycle.
- cpu_rvalid, output, 1: one-cycle pulse; cpu_rdata valid.
- cpu_rdata, output, DATA_W: CPU read data.
- dbg_hold, input, 1: while 1, the CPU is never granted.
- dbg_req, input, 1: debug access request; held until granted.
- dbg_we, input, 1: 1=write, 0=read.
- dbg_addr, input, MEMORY_BITS: debug word address.
- dbg_wdata, input, DATA_W: debug write data.
- dbg_ack, output, 1: one-cycle pulse the cycle after a debug grant (reads and writes).
- dbg_rdata, output, DATA_W: debug read data, valid with dbg_ack on reads.
- dm_en, output, 1: DM access strobe.
- dm_we, output, 1: DM write enable.
- dm_addr, output, MEMORY_BITS: DM address.
- dm_wdata, output, DATA_W: DM write data.
- dm_rdata, input, DATA_W: DM read data, valid the cycle after dm_en with dm_we=0.
- stall_cycles, output, 32: statistics counter (see ARB_STATS_EN).
- dbg_grants, output, 32: statistics counter (see ARB_STATS_EN).

Behaviour:
- Grant decision is combinational, one winner per cycle:
  - force = dbg_req && (dbg_hold || wait_cnt == MAX_WAIT).
  - dbg_gnt = dbg_req && (force || !cpu_req).
  - cpu_gnt = cpu_req && !dbg_hold && !dbg_gnt.
- DM drive:
  - dm_en = cpu_gnt | dbg_gnt.
  - dm_we/dm_addr/dm_wdata come from the winner.
  - With no winner: dm_en=0, dm_we=0, address and data 0.
- cpu_stall = cpu_req && !cpu_gnt.
- wait_cnt (8-bit) update:
  - cleared on dbg_gnt or when !dbg_req;
  - incremented when dbg_req && !dbg_gnt;
  - saturates at MAX_WAIT.
- Response FSM, registered state resp:
  - states IDLE, CPU_RD, CPU_WR, DBG_RD, DBG_WR;
  - next state follows the grant and cpu_we/dbg_we, else IDLE.
- Outputs by resp state:
  - CPU_RD: cpu_rvalid=1, cpu_rdata=dm_rdata.
  - DBG_RD: dbg_ack=1, dbg_rdata=dm_rdata.
  - DBG_WR: dbg_ack=1, dbg_rdata=0.
  - CPU_WR: no response pulse.
  - cpu_rdata and dbg_rdata read 0 when their response is not valid.
- Back-to-back grants are allowed: a new issue may coincide with the previous response cycle.
- Latency: grant cycle N, response cycle N+1.
- A CPU write is committed at its grant cycle; cpu_stall deasserts that same cycle.
- Simultaneous requests:
  - the CPU wins unless force is set;
  - e.g. with MAX_WAIT=8, the debug port is granted on its 9th pending cycle.
- dbg_hold=1 with no dbg_req: cpu_stall=cpu_req and DM is idle.
- Requesters must keep req/we/addr/wdata stable until granted; behaviour otherwise is undefined.
- Reset (rst=0, asynchronous):
  - resp=IDLE, wait_cnt=0, counters 0.
  - All outputs 0, except cpu_stall, which stays combinational from cpu_req.
  - A read in flight at reset is discarded; no rvalid/ack pulse after rst is released.

Optional Feature:
- ARB_STATS_EN defined:
  - stall_cycles increments each cycle cpu_stall=1;
  - dbg_grants increments on each dbg_gnt;
  - both saturate at 32'hFFFF_FFFF and clear on reset;
  - the simulation top prints them alongside StallCount.
- Not defined: both ports are tied to 0 and no counter flops are generated.

Test Plan:
- CPU read only: DM[5]=32'hDEAD_BEEF, cpu_req=1, we=0, addr=5 → dm_en at cycle N, cpu_rvalid at N+1 with cpu_rdata=32'hDEAD_BEEF, cpu_stall=0 throughout.
- Debug write then read: write addr=10, data=32'h1234 → dbg_ack at N+1; read addr=10 → dbg_ack at N+3, dbg_rdata=32'h1234.
- Starvation, MAX_WAIT=8: cpu_req held 1 every cycle, dbg_req raised at cycle 0:
  - the CPU wins cycles 0..7;
  - dbg granted at cycle 8 with cpu_stall=1 there;
  - dbg_ack at 9; the CPU is granted again at 9.
- dbg_hold=1 with cpu_req=1:
  - cpu_stall stays 1 for 20 cycles;
  - debug writes addr 0..3 each ack;
  - releasing hold grants the CPU the same cycle.
- Reset mid-read: CPU read granted at N, rst=0 at N+0.5 → cpu_rvalid stays 0, resp=IDLE, all outputs 0 after rst is released.
- ARB_STATS_EN: repeat the starvation scenario → stall_cycles=1, dbg_grants=1.
